rand_byte_gen: RTL and testbench

Pseudo-random byte source that feeds the 8-bit value input of the 1-to-6 dice mapper in the Craps datapath.
- A 16-bit Galois LFSR free-runs on every enabled clock, so player timing adds entropy.
- A roll request starts a fixed-length decorrelation run. At the end it presents one fresh byte on value with a value_valid strobe.
- Supports reseeding and shares the clock_en gating used by the dice mapper.

---
 rtl/rand_pkg.sv | 20 ++
 rtl/rand_byte_gen_lfsr16.sv | 28 ++
 rtl/rand_byte_gen.sv | 92 +++++++++
 tb/tb_rand_byte_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types, widths and the LFSR step function for the random byte source.
package rand_pkg;

    localparam int unsigned LFSR_W         = 16;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned CNT_W          = 8;
    localparam logic [LFSR_W-1:0] TAPS           = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT_C = 16'hACE1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Right-shifting Galois step; a non-zero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/rand_byte_gen_lfsr16.sv
// 16-bit Galois LFSR register with clock enable, seed load and free-running step.
module lfsr16
    import rand_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    // A zero seed would lock the LFSR, so it is replaced by the default.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED_DEFAULT;
        end else if (en) begin
            if (load) begin
                state <= (seed == LFSR_W'(0)) ? SEED_DEFAULT : seed;
            end else begin
                state <= lfsr_next(state);
            end
        end
    end

endmodule

// File: rtl/rand_byte_gen.sv
// Roll-request front end: runs a fixed decorrelation burst, then latches one LFSR byte.
module rand_byte_gen
    import rand_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEFAULT_C,
    parameter int unsigned       SHIFTS       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clock_en,
    input  logic              roll_req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [BYTE_W-1:0] value,
    output logic              value_valid,
    output logic              busy,
    output logic [LFSR_W-1:0] lfsr_state
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BYTE_W-1:0]  value_d;
    logic               valid_d;
    logic               busy_d;

    lfsr16 #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .en    (clock_en),
        .load  (seed_load),
        .seed  (seed),
        .state (lfsr_state)
    );

    // State and output registers; everything freezes while clock_en is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            busy        <= 1'b0;
        end else if (clock_en) begin
            state_q     <= state_d;
            count_q     <= count_d;
            value       <= value_d;
            value_valid <= valid_d;
            busy        <= busy_d;
        end
    end

    // Seed load aborts any roll; the final SHIFT edge captures the post-step byte.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        value_d = value;
        valid_d = 1'b0;
        busy_d  = busy;

        if (seed_load) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (roll_req) begin
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                        count_d = CNT_W'(SHIFTS - 1);
                    end
                end
                SHIFT: begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        value_d = BYTE_W'(lfsr_next(lfsr_state));
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_byte_gen.sv
// Scoreboard bench for rand_byte_gen: directed test-plan cases plus a randomized soak.
module tb_rand_byte_gen;

    localparam int unsigned SHIFTS = 8;
    localparam logic [15:0] SEED_DEF = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset;
    logic        clock_en;
    logic        roll_req;
    logic        seed_load;
    logic [15:0] seed;
    logic [7:0]  value;
    logic        value_valid;
    logic        busy;
    logic [15:0] lfsr_state;

    int n_checks = 0;
    int n_fail   = 0;

    rand_byte_gen #(
        .SEED_DEFAULT (SEED_DEF),
        .SHIFTS       (SHIFTS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clock_en    (clock_en),
        .roll_req    (roll_req),
        .seed_load   (seed_load),
        .seed        (seed),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .lfsr_state  (lfsr_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference LFSR arithmetic straight from the tap polynomial.
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return (s >> 1) ^ ((s & 16'd1) != 0 ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] ref_advance(input logic [15:0] s, input int n);
        logic [15:0] r = s;
        for (int i = 0; i < n; i++) r = ref_step(r);
        return r;
    endfunction

    // ---------------- reference model (updated on every rising edge) ----------------
    logic [15:0] m_lfsr;
    logic        m_busy;
    logic        m_valid;
    logic [7:0]  m_value;
    int          m_left;
    logic        m_pop;
    bit          mon_on = 1'b0;
    logic [7:0]  exp_q[$];

    always @(posedge clock) begin
        m_pop = 1'b0;
        if (reset) begin
            m_lfsr  = SEED_DEF;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_value = 8'h00;
            m_left  = 0;
            exp_q.delete();
            mon_on  = 1'b1;
        end else if (clock_en) begin
            m_valid = 1'b0;
            if (seed_load) begin
                m_lfsr = (seed == 16'h0000) ? SEED_DEF : seed;
                if (m_busy && exp_q.size() > 0) void'(exp_q.pop_back());
                m_busy = 1'b0;
            end else begin
                if (!m_busy && roll_req) begin
                    m_busy = 1'b1;
                    m_left = SHIFTS;
                    // The byte is fixed at accept time: SHIFTS+1 steps ahead, low 8 bits.
                    exp_q.push_back(8'(ref_advance(m_lfsr, SHIFTS + 1)));
                end else if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy  = 1'b0;
                        m_valid = 1'b1;
                        m_pop   = 1'b1;
                    end
                end
                m_lfsr = ref_step(m_lfsr);
            end
        end
    end

    // ---------------- monitor (compares away from the active edge) ----------------
    always @(negedge clock) begin
        if (mon_on) begin
            check("lfsr_state", 32'(lfsr_state), 32'(m_lfsr));
            check("busy", 32'(busy), 32'(m_busy));
            check("value_valid", 32'(value_valid), 32'(m_valid));
            if (m_pop) begin
                m_pop = 1'b0;
                if (exp_q.size() == 0) begin
                    check("strobe_expected", 32'(1), 32'(0));
                end else begin
                    m_value = exp_q.pop_front();
                end
            end
            check("value", 32'(value), 32'(m_value));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic en, input logic rr,
                        input logic sl, input logic [15:0] sd);
        reset     = rst;
        clock_en  = en;
        roll_req  = rr;
        seed_load = sl;
        seed      = sd;
        @(negedge clock);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    logic [15:0] seq [0:8] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E,
                               16'h0E27, 16'hB313, 16'hED89, 16'hC2C4};

    initial begin
        int n;
        int n_clk;
        int strobes;
        int last_idx;
        logic [7:0] old_value;

        reset = 1'b1; clock_en = 1'b0; roll_req = 1'b0; seed_load = 1'b0; seed = '0;
        @(negedge clock);

        // Reset values and the free-running sequence
        do_reset();
        check("rst_lfsr", 32'(lfsr_state), 32'h0000ACE1);
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(value_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        for (int i = 1; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            check("free_run_seq", 32'(lfsr_state), 32'(seq[i]));
        end

        // Single roll right after reset
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        check("accept_busy", 32'(busy), 32'h1);
        n = 0;
        while (!value_valid && n < 20) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            n++;
        end
        check("roll_latency", 32'(n), 32'(SHIFTS));
        check("roll_value", 32'(value), 32'h62);
        check("roll_lfsr", 32'(lfsr_state), 32'h6162);
        check("roll_busy_low", 32'(busy), 32'h0);

        // Same roll with a 5-clock enable gap mid-SHIFT
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
            check("gap_lfsr_frozen", 32'(lfsr_state), 32'(ref_advance(SEED_DEF, 4)));
            check("gap_busy", 32'(busy), 32'h1);
        end
        n_clk = 8;
        while (!value_valid && n_clk < 40) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            n_clk++;
        end
        check("gap_latency", 32'(n_clk), 32'(SHIFTS + 5));
        check("gap_value", 32'(value), 32'h62);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("strobe_held_while_disabled", 32'(value_valid), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("strobe_single", 32'(value_valid), 32'h0);

        // Seeding
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        check("seed_zero", 32'(lfsr_state), 32'h0000ACE1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);
        check("seed_one", 32'(lfsr_state), 32'h00000001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("seed_one_step", 32'(lfsr_state), 32'h0000B400);

        // Seed load aborts an in-flight roll
        old_value = 8'h62;
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_lfsr", 32'(lfsr_state), 32'h1234);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            check("abort_no_strobe", 32'(value_valid), 32'h0);
        end
        check("abort_value_kept", 32'(value), 32'(old_value));

        // roll_req held: back-to-back rolls SHIFTS+1 edges apart
        do_reset();
        strobes = 0; last_idx = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
            if (value_valid) begin
                if (last_idx >= 0) check("held_spacing", 32'(i - last_idx), 32'(SHIFTS + 1));
                last_idx = i;
                strobes++;
            end
        end
        check("held_strobes", 32'(strobes), 32'd3);
        n = 0;
        while (busy && n < 20) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            n++;
        end

        // Extra roll pulses during busy neither shorten nor add rolls
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        n = 0; strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0) && (i < 6), 1'b0, 16'h0);
            if (value_valid) begin
                strobes++;
                if (strobes == 1) n = i + 1;
            end
        end
        check("pulse_latency", 32'(n), 32'(SHIFTS));
        check("pulse_strobes", 32'(strobes), 32'd1);

        // Reset mid-SHIFT
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("midreset_lfsr", 32'(lfsr_state), 32'h0000ACE1);
        check("midreset_value", 32'(value), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_valid", 32'(value_valid), 32'h0);

        // Randomized soak against the model
        for (int i = 0; i < 2000; i++) begin
            logic rst_r, en_r, rr_r, sl_r;
            logic [15:0] sd_r;
            rst_r = ($urandom_range(0, 199) == 0);
            en_r  = ($urandom_range(0, 3) != 0);
            rr_r  = ($urandom_range(0, 9) < 3);
            sl_r  = ($urandom_range(0, 39) == 0);
            sd_r  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            step(rst_r, en_r, rr_r, sl_r, sd_r);
        end

        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < SHIFTS + 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
